pipe_scoreboard: RTL

Parametrised register scoreboard, the successor to the fixed 5-stage hazard-detection/forwarding pair in the MIPS pipeline top. It tracks every in-flight register write with a per-register busy bit, a latency countdown and a write tag. From this it stalls ID for operands not yet forwardable, and tells ID when a pending operand is available on the bypass network. It supports variable producer latency (ALU, load, multi-cycle units) and out-of-order writeback safety via tags.

---
 rtl/pipe_sb_pkg.sv | 21 ++
 rtl/sb_entry.sv | 51 +++++
 rtl/pipe_scoreboard.sv | 83 ++++++++
 3 files changed

// File: rtl/pipe_sb_pkg.sv
// rtl/pipe_sb_pkg.sv - shared defaults, entry type and hazard predicate for pipe_scoreboard
package pipe_sb_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int LAT_W_DEF    = 3;
  localparam int TAG_W_DEF    = 3;

  typedef struct packed {
    logic                 busy;
    logic [LAT_W_DEF-1:0] cnt;
    logic [TAG_W_DEF-1:0] tag;
  } sb_entry_t;

  // A source must wait while its producer is in flight and not yet on the bypass.
  function automatic logic src_hazard(input logic used, input logic nonzero,
                                      input logic busy, input logic cnt_nz);
    return used & nonzero & busy & cnt_nz;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - busy/countdown/tag state for one architectural register
module sb_entry #(
  parameter int LAT_W = 3,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             wb_hit,
  input  logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic [LAT_W-1:0] cnt,
  output logic [TAG_W-1:0] tag
);

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // A new issue overrides a same-cycle retire so the newer producer stays tracked.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = (busy_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    tag_d  = tag_q;
    if (wb_hit && busy_q && tag_q == wb_tag) busy_d = 1'b0;
    if (set) begin
      busy_d = 1'b1;
      cnt_d  = set_lat;
      tag_d  = set_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end

  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign tag  = tag_q;

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - register scoreboard driving ID stall and bypass-select
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_src1,
  input  logic [REG_AW-1:0] iss_src2,
  input  logic              iss_src1_used,
  input  logic              iss_src2_used,
  input  logic              iss_wb_en,
  input  logic [REG_AW-1:0] iss_dest,
  input  logic [LAT_W-1:0]  iss_lat,
  input  logic              iss_flush,
  output logic [TAG_W-1:0]  iss_tag,
  output logic              stall,
  output logic              fwd1_pend,
  output logic              fwd2_pend,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [TAG_W-1:0]  wb_tag,
  output logic [31:0]       stall_count
);

  logic             busy [NUM_REGS];
  logic [LAT_W-1:0] cnt  [NUM_REGS];
  logic [TAG_W-1:0] tag  [NUM_REGS];

  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic [31:0]      stall_count_q, stall_count_d;
  logic             haz1, haz2, issue_ok;

  assign busy[0] = 1'b0;
  assign cnt[0]  = '0;
  assign tag[0]  = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W), .TAG_W(TAG_W)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (issue_ok && iss_dest == REG_AW'(i)),
      .set_lat (iss_lat),
      .set_tag (next_tag_q),
      .wb_hit  (wb_valid && wb_dest == REG_AW'(i)),
      .wb_tag  (wb_tag),
      .busy    (busy[i]),
      .cnt     (cnt[i]),
      .tag     (tag[i])
    );
  end

  always_comb begin
    haz1      = src_hazard(iss_src1_used, iss_src1 != '0, busy[iss_src1], cnt[iss_src1] != '0);
    haz2      = src_hazard(iss_src2_used, iss_src2 != '0, busy[iss_src2], cnt[iss_src2] != '0);
    stall     = iss_valid & ~iss_flush & (haz1 | haz2);
    fwd1_pend = iss_src1_used & (iss_src1 != '0) & busy[iss_src1] & (cnt[iss_src1] == '0);
    fwd2_pend = iss_src2_used & (iss_src2 != '0) & busy[iss_src2] & (cnt[iss_src2] == '0);
    issue_ok  = iss_valid & ~iss_flush & ~stall & iss_wb_en & (iss_dest != '0);
    iss_tag   = next_tag_q;
    next_tag_d    = issue_ok ? next_tag_q + 1'b1 : next_tag_q;
    stall_count_d = (stall && stall_count_q != 32'hFFFF_FFFF) ? stall_count_q + 32'd1
                                                              : stall_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag_q    <= '0;
      stall_count_q <= '0;
    end else begin
      next_tag_q    <= next_tag_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
